// File: rtl/ex_mem_pipe_stage_if.sv
// Handshake bundle for the elastic EX/MEM stage.
// The upstream/downstream environment uses master; the stage itself uses slave.
interface ex_mem_pipe_stage_if #(
   parameter int unsigned DW = 101,
   parameter int unsigned CW = 6
);
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          in_zero;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic          out_zero;
   logic [1:0]    occupancy;

   modport master (
      output flush, in_valid, in_data, in_ctrl, in_zero, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl, out_zero, occupancy
   );

   modport slave (
      input  flush, in_valid, in_data, in_ctrl, in_zero, out_ready,
      output in_ready, out_valid, out_data, out_ctrl, out_zero, occupancy
   );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// Elastic EX/MEM boundary: valid/ready stage with a 2-entry skid buffer and flush.
// Handshake outputs depend on registered state only, so stalls never form a comb path.
module ex_mem_pipe_stage #(
   parameter int unsigned DW = 101,
   parameter int unsigned CW = 6
) (
   input logic                clk,
   input logic                rst,
   ex_mem_pipe_stage_if.slave bus
);

   typedef enum logic [1:0] {StEmpty, StHalf, StFull} state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
   logic [CW-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
   logic          m_zero_q, m_zero_d, s_zero_q, s_zero_d;
   logic          acc, pop;

   assign bus.in_ready  = (state_q != StFull);
   assign bus.out_valid = (state_q != StEmpty);
   assign acc           = bus.in_valid & bus.in_ready;
   assign pop           = bus.out_valid & bus.out_ready;

   always_comb begin
      state_d  = state_q;
      m_data_d = m_data_q;
      m_ctrl_d = m_ctrl_q;
      m_zero_d = m_zero_q;
      s_data_d = s_data_q;
      s_ctrl_d = s_ctrl_q;
      s_zero_d = s_zero_q;
      if (bus.flush) begin
         // Data may stay stale; clearing ctrl is what turns entries into bubbles.
         state_d  = StEmpty;
         m_ctrl_d = '0;
         s_ctrl_d = '0;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (acc) begin
                  state_d  = StHalf;
                  m_data_d = bus.in_data;
                  m_ctrl_d = bus.in_ctrl;
                  m_zero_d = bus.in_zero;
               end
            end
            StHalf: begin
               if (acc && pop) begin
                  m_data_d = bus.in_data;
                  m_ctrl_d = bus.in_ctrl;
                  m_zero_d = bus.in_zero;
               end else if (acc) begin
                  state_d  = StFull;
                  s_data_d = bus.in_data;
                  s_ctrl_d = bus.in_ctrl;
                  s_zero_d = bus.in_zero;
               end else if (pop) begin
                  state_d = StEmpty;
               end
            end
            StFull: begin
               if (pop) begin
                  state_d  = StHalf;
                  m_data_d = s_data_q;
                  m_ctrl_d = s_ctrl_q;
                  m_zero_d = s_zero_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StEmpty;
         m_data_q <= '0;
         m_ctrl_q <= '0;
         m_zero_q <= 1'b0;
         s_data_q <= '0;
         s_ctrl_q <= '0;
         s_zero_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_data_q <= m_data_d;
         m_ctrl_q <= m_ctrl_d;
         m_zero_q <= m_zero_d;
         s_data_q <= s_data_d;
         s_ctrl_q <= s_ctrl_d;
         s_zero_q <= s_zero_d;
      end
   end

   assign bus.out_data = m_data_q;
   assign bus.out_zero = m_zero_q;
   // Masked so a popped entry's stale ctrl can never leak onto a bubble.
   assign bus.out_ctrl = bus.out_valid ? m_ctrl_q : '0;

   always_comb begin
      unique case (state_q)
         StHalf:  bus.occupancy = 2'd1;
         StFull:  bus.occupancy = 2'd2;
         default: bus.occupancy = 2'd0;
      endcase
   end

endmodule
